// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset/bubble defaults, fetch FSM encoding and the
// fetch entry record used by the IF stage, decode and hazard logic.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    localparam logic [1:0] FETCH_IDLE = 2'd0;
    localparam logic [1:0] FETCH_WAIT = 2'd1;
    localparam logic [1:0] FETCH_DROP = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer that parks a fetched instruction while decode is
// stalled, so the in-flight response is never lost.
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  fetch_entry_t wr_data,
    input  logic         rd_en,
    input  logic         clr,
    output logic         full,
    output fetch_entry_t rd_data
);

    fetch_entry_t entry;

    // Clear wins over write so a redirect always empties the buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full  <= 1'b0;
            entry <= '0;
        end else begin
            if (clr)
                full <= 1'b0;
            else if (wr_en)
                full <= 1'b1;
            else if (rd_en)
                full <= 1'b0;

            if (wr_en && !clr)
                entry <= wr_data;
        end
    end

    assign rd_data = entry;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding-request fetch FSM, skid buffer
// and IF/ID pipeline register with stall and redirect handling.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        PCSrc,
    input  logic [31:0] TargetPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_ID,
    output logic [31:0] Instruction_ID,
    output logic        Valid_ID
);

    logic [1:0]   state;
    logic [1:0]   state_next;
    logic [31:0]  pc;
    logic [31:0]  req_pc;
    logic         accept;
    logic         discard;
    logic         use_resp;
    logic         skid_wr;
    logic         skid_rd;
    logic         skid_full;
    logic         skid_full_next;
    logic         issue;
    fetch_entry_t skid_data;

    // Responses only count while a request is outstanding; DROP or a
    // same-cycle redirect makes the returning instruction stale.
    assign accept   = imem_rvalid && ((state == FETCH_WAIT) || (state == FETCH_DROP));
    assign discard  = (state == FETCH_DROP) || PCSrc;
    assign use_resp = accept && !discard;

    assign skid_wr        = use_resp && Stall;
    assign skid_rd        = skid_full && !Stall && !PCSrc;
    assign skid_full_next = !PCSrc && (skid_wr || (skid_full && Stall));

    // Never fetch ahead of a parked instruction: issuing only with an empty
    // buffer guarantees the next response always has somewhere to go.
    assign issue = !reset && !PCSrc && ((state == FETCH_IDLE) || accept) && !skid_full_next;

    assign imem_req  = issue;
    assign imem_addr = pc;

    fetch_skid_buf u_skid (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (skid_wr),
        .wr_data ('{pc: req_pc, instr: imem_rdata}),
        .rd_en   (skid_rd),
        .clr     (PCSrc),
        .full    (skid_full),
        .rd_data (skid_data)
    );

    // A redirect with a request still in flight must remember to drop it.
    always_comb begin
        state_next = state;
        if (PCSrc)
            state_next = ((state != FETCH_IDLE) && !accept) ? FETCH_DROP : FETCH_IDLE;
        else if (issue)
            state_next = FETCH_WAIT;
        else if (accept)
            state_next = FETCH_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= FETCH_IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            state <= state_next;
            if (PCSrc) begin
                pc <= TargetPC;
            end else if (issue) begin
                pc     <= next_seq_pc(pc);
                req_pc <= pc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC_ID          <= 32'h0000_0000;
            Instruction_ID <= NOP_INSTR;
            Valid_ID       <= 1'b0;
        end else if (PCSrc) begin
            Instruction_ID <= NOP_INSTR;
            Valid_ID       <= 1'b0;
        end else if (!Stall) begin
            if (skid_full) begin
                PC_ID          <= skid_data.pc;
                Instruction_ID <= skid_data.instr;
                Valid_ID       <= 1'b1;
            end else if (use_resp) begin
                PC_ID          <= req_pc;
                Instruction_ID <= imem_rdata;
                Valid_ID       <= 1'b1;
            end else begin
                Instruction_ID <= NOP_INSTR;
                Valid_ID       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a variable-latency memory model returns
// addr ^ 32'hDEAD_0000 as the instruction word for each fetched address.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        PCSrc;
    logic [31:0] TargetPC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] PC_ID;
    logic [31:0] Instruction_ID;
    logic        Valid_ID;

    int          mem_lat;
    logic        stray_req;
    int          pass_cnt = 0;
    int          check_cnt = 0;

    logic        req_seen;
    logic [31:0] addr_seen;
    logic [31:0] pend_addr;
    int          pend_cnt;

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .Stall          (Stall),
        .PCSrc          (PCSrc),
        .TargetPC       (TargetPC),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .PC_ID          (PC_ID),
        .Instruction_ID (Instruction_ID),
        .Valid_ID       (Valid_ID)
    );

    always #5 clk = ~clk;

    // Memory: a request seen in cycle n answers in cycle n+mem_lat.
    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        pend_cnt    = 0;
        pend_addr   = 32'h0;
        forever begin
            @(negedge clk);
            req_seen  = imem_req;
            addr_seen = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (reset) begin
                pend_cnt = 0;
            end else begin
                if (req_seen) begin
                    pend_addr = addr_seen;
                    pend_cnt  = mem_lat;
                end
                if (pend_cnt > 0) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = pend_addr ^ 32'hDEAD_0000;
                    end
                end
            end
            if (stray_req) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hBAD0_BAD0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_cnt++;
        if (imem_req !== 1'b0)
            $display("[TB] FAIL reset_req: got %b want 0", imem_req);
        else pass_cnt++;
        check_cnt++;
        if ({PC_ID, Instruction_ID, Valid_ID} !== {32'h0, NOP, 1'b0})
            $display("[TB] FAIL reset_ifid: got pc=%h instr=%h v=%b want pc=00000000 instr=00000013 v=0", PC_ID, Instruction_ID, Valid_ID);
        else pass_cnt++;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_stream();
        @(negedge clk);
        check_cnt++;
        if ({imem_req, imem_addr, Valid_ID} !== {1'b1, 32'h0, 1'b0})
            $display("[TB] FAIL stream_fetch0: got req=%b addr=%h v=%b want req=1 addr=00000000 v=0", imem_req, imem_addr, Valid_ID);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        check_cnt++;
        if ({imem_req, imem_addr, Valid_ID} !== {1'b1, 32'h4, 1'b0})
            $display("[TB] FAIL stream_fetch4: got req=%b addr=%h v=%b want req=1 addr=00000004 v=0", imem_req, imem_addr, Valid_ID);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        check_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h8})
            $display("[TB] FAIL stream_fetch8: got req=%b addr=%h want req=1 addr=00000008", imem_req, imem_addr);
        else pass_cnt++;
        check_cnt++;
        if ({PC_ID, Instruction_ID, Valid_ID} !== {32'h0, 32'hDEAD_0000, 1'b1})
            $display("[TB] FAIL stream_ifid0: got pc=%h instr=%h v=%b want pc=00000000 instr=dead0000 v=1", PC_ID, Instruction_ID, Valid_ID);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_stall();
        Stall = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (imem_req !== 1'b0)
            $display("[TB] FAIL stall_noreq1: got req=%b want 0", imem_req);
        else pass_cnt++;
        check_cnt++;
        if ({PC_ID, Instruction_ID, Valid_ID} !== {32'h4, 32'hDEAD_0004, 1'b1})
            $display("[TB] FAIL stall_ifid4a: got pc=%h instr=%h v=%b want pc=00000004 instr=dead0004 v=1", PC_ID, Instruction_ID, Valid_ID);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        check_cnt++;
        if ({imem_req, PC_ID, Instruction_ID, Valid_ID} !== {1'b0, 32'h4, 32'hDEAD_0004, 1'b1})
            $display("[TB] FAIL stall_hold: got req=%b pc=%h instr=%h v=%b want req=0 pc=00000004 instr=dead0004 v=1", imem_req, PC_ID, Instruction_ID, Valid_ID);
        else pass_cnt++;
        next_cycle();
        Stall = 1'b0;
        @(negedge clk);
        check_cnt++;
        if ({imem_req, imem_addr, PC_ID} !== {1'b1, 32'hC, 32'h4})
            $display("[TB] FAIL stall_release: got req=%b addr=%h pc=%h want req=1 addr=0000000c pc=00000004", imem_req, imem_addr, PC_ID);
        else pass_cnt++;
        next_cycle();
        mem_lat = 3;
        @(negedge clk);
        check_cnt++;
        if ({PC_ID, Instruction_ID, Valid_ID} !== {32'h8, 32'hDEAD_0008, 1'b1})
            $display("[TB] FAIL stall_skid8: got pc=%h instr=%h v=%b want pc=00000008 instr=dead0008 v=1", PC_ID, Instruction_ID, Valid_ID);
        else pass_cnt++;
        check_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h10})
            $display("[TB] FAIL stall_fetch10: got req=%b addr=%h want req=1 addr=00000010", imem_req, imem_addr);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        check_cnt++;
        if ({imem_req, PC_ID, Instruction_ID, Valid_ID} !== {1'b0, 32'hC, 32'hDEAD_000C, 1'b1})
            $display("[TB] FAIL stall_ifid12: got req=%b pc=%h instr=%h v=%b want req=0 pc=0000000c instr=dead000c v=1", imem_req, PC_ID, Instruction_ID, Valid_ID);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_redirect_drop();
        PCSrc    = 1'b1;
        TargetPC = 32'h100;
        @(negedge clk);
        check_cnt++;
        if ({imem_req, PC_ID, Instruction_ID, Valid_ID} !== {1'b0, 32'hC, NOP, 1'b0})
            $display("[TB] FAIL drop_redirect: got req=%b pc=%h instr=%h v=%b want req=0 pc=0000000c instr=00000013 v=0", imem_req, PC_ID, Instruction_ID, Valid_ID);
        else pass_cnt++;
        next_cycle();
        PCSrc = 1'b0;
        @(negedge clk);
        check_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h100})
            $display("[TB] FAIL drop_fetch100: got req=%b addr=%h want req=1 addr=00000100", imem_req, imem_addr);
        else pass_cnt++;
        next_cycle();
        mem_lat = 1;
        @(negedge clk);
        check_cnt++;
        if ({imem_req, PC_ID, Instruction_ID, Valid_ID} !== {1'b0, 32'hC, NOP, 1'b0})
            $display("[TB] FAIL drop_discarded: got req=%b pc=%h instr=%h v=%b want req=0 pc=0000000c instr=00000013 v=0", imem_req, PC_ID, Instruction_ID, Valid_ID);
        else pass_cnt++;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_cnt++;
        if ({imem_req, imem_addr, imem_rvalid} !== {1'b1, 32'h104, 1'b1})
            $display("[TB] FAIL drop_fetch104: got req=%b addr=%h rvalid=%b want req=1 addr=00000104 rvalid=1", imem_req, imem_addr, imem_rvalid);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_redirect_stall();
        Stall    = 1'b1;
        PCSrc    = 1'b1;
        TargetPC = 32'h200;
        @(negedge clk);
        check_cnt++;
        if ({imem_req, PC_ID, Instruction_ID, Valid_ID} !== {1'b0, 32'h100, 32'hDEAD_0100, 1'b1})
            $display("[TB] FAIL rstall_before: got req=%b pc=%h instr=%h v=%b want req=0 pc=00000100 instr=dead0100 v=1", imem_req, PC_ID, Instruction_ID, Valid_ID);
        else pass_cnt++;
        next_cycle();
        Stall = 1'b0;
        PCSrc = 1'b0;
        @(negedge clk);
        check_cnt++;
        if ({PC_ID, Instruction_ID, Valid_ID} !== {32'h100, NOP, 1'b0})
            $display("[TB] FAIL rstall_bubble: got pc=%h instr=%h v=%b want pc=00000100 instr=00000013 v=0", PC_ID, Instruction_ID, Valid_ID);
        else pass_cnt++;
        check_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h200})
            $display("[TB] FAIL rstall_target: got req=%b addr=%h want req=1 addr=00000200", imem_req, imem_addr);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_wrap();
        PCSrc    = 1'b1;
        TargetPC = 32'hFFFF_FFFC;
        @(negedge clk);
        check_cnt++;
        if (imem_req !== 1'b0)
            $display("[TB] FAIL wrap_redirect_req: got %b want 0", imem_req);
        else pass_cnt++;
        next_cycle();
        PCSrc = 1'b0;
        @(negedge clk);
        check_cnt++;
        if ({imem_req, imem_addr, Valid_ID} !== {1'b1, 32'hFFFF_FFFC, 1'b0})
            $display("[TB] FAIL wrap_fetch_top: got req=%b addr=%h v=%b want req=1 addr=fffffffc v=0", imem_req, imem_addr, Valid_ID);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        check_cnt++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0})
            $display("[TB] FAIL wrap_fetch_zero: got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        check_cnt++;
        if ({PC_ID, Instruction_ID, Valid_ID} !== {32'hFFFF_FFFC, 32'h2152_FFFC, 1'b1})
            $display("[TB] FAIL wrap_ifid: got pc=%h instr=%h v=%b want pc=fffffffc instr=2152fffc v=1", PC_ID, Instruction_ID, Valid_ID);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        #1;
        reset = 1'b1;
        #1;
        check_cnt++;
        if ({imem_req, PC_ID, Instruction_ID, Valid_ID} !== {1'b0, 32'h0, NOP, 1'b0})
            $display("[TB] FAIL areset_immediate: got req=%b pc=%h instr=%h v=%b want req=0 pc=00000000 instr=00000013 v=0", imem_req, PC_ID, Instruction_ID, Valid_ID);
        else pass_cnt++;
        next_cycle();
        stray_req = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_cnt++;
        if ({imem_req, imem_addr, imem_rvalid} !== {1'b1, 32'h0, 1'b1})
            $display("[TB] FAIL areset_fetch0: got req=%b addr=%h rvalid=%b want req=1 addr=00000000 rvalid=1", imem_req, imem_addr, imem_rvalid);
        else pass_cnt++;
        stray_req = 1'b0;
        next_cycle();
        @(negedge clk);
        check_cnt++;
        if ({PC_ID, Instruction_ID, Valid_ID} !== {32'h0, NOP, 1'b0})
            $display("[TB] FAIL areset_stray_ignored: got pc=%h instr=%h v=%b want pc=00000000 instr=00000013 v=0", PC_ID, Instruction_ID, Valid_ID);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        check_cnt++;
        if ({PC_ID, Instruction_ID, Valid_ID} !== {32'h0, 32'hDEAD_0000, 1'b1})
            $display("[TB] FAIL areset_first_instr: got pc=%h instr=%h v=%b want pc=00000000 instr=dead0000 v=1", PC_ID, Instruction_ID, Valid_ID);
        else pass_cnt++;
    endtask

    initial begin
        reset     = 1'b1;
        Stall     = 1'b0;
        PCSrc     = 1'b0;
        TargetPC  = 32'h0;
        mem_lat   = 1;
        stray_req = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_stall();
        test_wrap();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), bubble instruction.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port Stall  in  1  hazard hold; IF/ID keeps its contents.
REQ-006 SHALL have port PCSrc  in  1  redirect request (taken branch / jump resolved downstream).
REQ-007 SHALL have port TargetPC  in  32  redirect address, valid when PCSrc=1.
REQ-008 SHALL have port imem_req  out  1  fetch request, one cycle per request.
REQ-009 SHALL have port imem_addr  out  32  fetch address, valid with imem_req.
REQ-010 SHALL have port imem_rvalid  in  1  fetch response strobe, at least one cycle after its request.
REQ-011 SHALL have port imem_rdata  in  32  fetched instruction, valid with imem_rvalid.
REQ-012 SHALL have port PC_ID  out  32  IF/ID register: address of Instruction_ID.
REQ-013 SHALL have port Instruction_ID  out  32  IF/ID register: instruction presented to decode.
REQ-014 SHALL have port Valid_ID  out  1  IF/ID register: 1 = real instruction, 0 = bubble.

Function
REQ-015 SHALL track fetch state in FSM IDLE (none outstanding), WAIT (one outstanding), DROP (one outstanding, response to be discarded); at most one request outstanding.
REQ-016 SHALL accept a response only when imem_rvalid=1 in WAIT or DROP; imem_rvalid in IDLE SHALL be ignored.
REQ-017 SHALL discard an accepted response in DROP, or in WAIT when PCSrc=1 in the same cycle.
REQ-018 SHALL hold a one-entry skid buffer {pc, instr, full}; a non-discarded accepted response with Stall=1 and PCSrc=0 SHALL be written into it.
REQ-019 SHALL assert imem_req when PCSrc=0, and (state IDLE or a response is accepted this cycle), and the skid buffer will be empty at end of cycle.
REQ-020 SHALL drive imem_addr=PC; on issue PC<=PC+4 (modulo 2^32 wrap), req_pc<=PC.
REQ-021 SHALL, when Stall=0 and PCSrc=0, load IF/ID from, in priority: skid buffer (then clear it); accepted non-discarded response {req_pc, imem_rdata}; else bubble {PC_ID unchanged, NOP_INSTR, Valid 0}.
REQ-022 SHALL, when Stall=1 and PCSrc=0, hold IF/ID unchanged.
REQ-023 SHALL, on PCSrc=1 (priority over Stall): PC<=TargetPC; clear skid buffer; load IF/ID bubble; imem_req=0; next state DROP if WAIT without rvalid, else IDLE.
REQ-024 SHALL transition WAIT->IDLE on accept without new issue, WAIT->WAIT on accept with issue, DROP->IDLE on accept, IDLE->WAIT on issue.
REQ-025 SHALL give 1-instruction-per-cycle throughput with 1-cycle memory latency and no stalls; first request issued in first cycle after reset release.

Reset
REQ-026 SHALL on reset: PC=RESET_PC, state IDLE, skid buffer empty, PC_ID=0, Instruction_ID=NOP_INSTR, Valid_ID=0; imem_req=0 while reset asserted.
REQ-027 SHALL abandon any outstanding request on reset; a response arriving after release in IDLE is ignored per REQ-016.

Structure
REQ-028 SHALL take NOP_INSTR default, RESET_PC default and FSM state encoding from shared package cpu_pkg, also used by decode and hazard logic.
REQ-029 SHALL place the skid buffer in sub-module fetch_skid_buf (one entry, write/read/clear, full flag).

Verification
REQ-030 SHALL verify: reset release, 1-cycle memory, no stall -> imem_addr 0,4,8 on consecutive cycles; PC_ID 0,4,8 with Valid_ID=1 one cycle behind the response.
REQ-031 SHALL verify: Stall high 2 cycles while response for addr 8 arrives -> IF/ID holds addr 4, response 8 in skid buffer, no new imem_req; on release PC_ID=8, then 12.
REQ-032 SHALL verify: PCSrc=1, TargetPC=0x100 while request for 0x10 outstanding with 3-cycle memory -> response for 0x10 discarded, Valid_ID=0, next imem_addr=0x100.
REQ-033 SHALL verify: PCSrc=1 and Stall=1 same cycle -> IF/ID bubble (Instruction_ID=0x00000013, Valid_ID=0), PC=TargetPC.
REQ-034 SHALL verify: PC=0xFFFF_FFFC issue -> next imem_addr=0x0000_0000; mid-stream asynchronous reset -> outputs at reset values immediately, stray imem_rvalid afterwards ignored.
